// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_ctrl_pkg
//  Description : Shared constants for the datapath sequencer: state codes,
//                datapath mux selects, load-enable bit positions and the
//                instruction op/cond fields the sequencer decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

    // Sequencer state encodings (4-bit, exported on the debug port)
    localparam logic [3:0] S_RST1    = 4'd0;
    localparam logic [3:0] S_RST2    = 4'd1;
    localparam logic [3:0] S_FETCH1  = 4'd2;
    localparam logic [3:0] S_FETCH2  = 4'd3;
    localparam logic [3:0] S_FETCH3  = 4'd4;
    localparam logic [3:0] S_DECODE  = 4'd5;
    localparam logic [3:0] S_ALU     = 4'd6;
    localparam logic [3:0] S_MADDR   = 4'd7;
    localparam logic [3:0] S_LD_WAIT = 4'd8;
    localparam logic [3:0] S_LD_WB   = 4'd9;
    localparam logic [3:0] S_ST_DATA = 4'd10;
    localparam logic [3:0] S_ST_WAIT = 4'd11;
    localparam logic [3:0] S_BR      = 4'd12;
    localparam logic [3:0] S_PC_UPD  = 4'd13;
    localparam logic [3:0] S_TRAP    = 4'd14;

    // Datapath mux selects
    localparam logic [1:0] MAR_SEL_ALU = 2'd0;
    localparam logic [1:0] MAR_SEL_PC  = 2'd1;
    localparam logic [1:0] MDR_SEL_RAM = 2'd0;
    localparam logic [1:0] MDR_SEL_RA  = 2'd1;
    localparam logic [1:0] CIN_SEL_ALU = 2'd2;
    localparam logic [1:0] CIN_SEL_MDR = 2'd3;
    localparam logic [1:0] nPC_SEL_ADD = 2'd0;
    localparam logic [1:0] nPC_SEL_BR  = 2'd2;
    localparam logic [1:0] ALU_SEL_RS2 = 2'd0;
    localparam logic [1:0] ALU_SEL_IMM = 2'd1;
    localparam logic       MOP_SEL_DATA  = 1'b0;
    localparam logic       MOP_SEL_FETCH = 1'b1;
    localparam logic       RA_SEL_RS1  = 1'b0;
    localparam logic       RA_SEL_RD   = 1'b1;

    // Bit positions inside le_n = {IRE,MDRE,MARE,PCE,nPCE,RFE,PSRE}
    localparam int LE_IRE  = 6;
    localparam int LE_MDRE = 5;
    localparam int LE_MARE = 4;
    localparam int LE_PCE  = 3;
    localparam int LE_NPCE = 2;
    localparam int LE_RFE  = 1;
    localparam int LE_PSRE = 0;

    // Instruction fields: op = IR[31:30], op2 = IR[24:22], cond = IR[28:25]
    localparam logic [1:0] OP_FMT2   = 2'b00;
    localparam logic [1:0] OP_ALU    = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;
    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;

    // Branch resolution; only Z participates for the supported conditions
    function automatic logic branch_taken(input logic [3:0] cond, input logic z);
        logic tk;
        case (cond)
            COND_BA:  tk = 1'b1;
            COND_BN:  tk = 1'b0;
            COND_BE:  tk = z;
            COND_BNE: tk = ~z;
            default:  tk = 1'b0;
        endcase
        return tk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mfc_timer
//  Description : Counts cycles spent in a memory wait state and flags the
//                last permitted cycle. The count is held at zero whenever the
//                sequencer is outside a wait state, so it is always zero on
//                entry (no wait state is ever entered from another one).
//  Revision    : 1.0 - initial release
// ============================================================================
module mfc_timer #(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    output logic o_expired
);

    localparam int c_W = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(MFC_TIMEOUT - 1);

    logic [c_W-1:0] r_cnt;

    // Wait-cycle counter; saturates on the final cycle so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_wait) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High during the MFC_TIMEOUT-th consecutive wait cycle
    assign o_expired = i_wait && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dp_sequencer
//  Description : Moore control sequencer for a SPARC-style datapath. Walks
//                fetch / decode / execute states, drives active-low load
//                enables and mux selects, and traps if memory never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] IR,
    input  logic        MFC,
    input  logic [3:0]  icc,
    output logic [6:0]  le_n,
    output logic        clr_n,
    output logic        MFA,
    output logic [1:0]  MAR_SEL,
    output logic [1:0]  MDR_SEL,
    output logic [1:0]  nPC_SEL,
    output logic [1:0]  ALU_SEL,
    output logic [1:0]  CIN_SEL,
    output logic        RA_SEL,
    output logic        MOP_SEL,
    output logic        nPC_ADD,
    output logic        alue,
    output logic [3:0]  state,
    output logic        trap
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_in_wait;
    logic       w_expired;
    logic       w_taken;
    logic [1:0] w_alu_sel;
    logic       w_unused_in;

    assign state     = r_state;
    assign w_in_wait = (r_state == S_FETCH2) || (r_state == S_LD_WAIT) ||
                       (r_state == S_ST_WAIT);
    assign w_taken   = branch_taken(IR[28:25], icc[2]);
    assign w_alu_sel = IR[13] ? ALU_SEL_IMM : ALU_SEL_RS2;

    // Instruction and flag bits this sequencer does not decode
    assign w_unused_in = ^{IR[29], IR[20:14], IR[12:0], icc[3], icc[1:0]};

    mfc_timer #(
        .MFC_TIMEOUT (MFC_TIMEOUT)
    ) u_mfc_timer (
        .clk       (Clk),
        .rst_n     (Clr),
        .i_wait    (w_in_wait),
        .o_expired (w_expired)
    );

    // State register; Clr low forces RST1 immediately
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= S_RST1;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; in wait states MFC wins over an expiring timer
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST1:   w_next = S_RST2;
            S_RST2:   w_next = S_FETCH1;
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: begin
                if (MFC)            w_next = S_FETCH3;
                else if (w_expired) w_next = S_TRAP;
            end
            S_FETCH3: w_next = S_DECODE;
            S_DECODE: begin
                case (IR[31:30])
                    OP_ALU:  w_next = S_ALU;
                    OP_MEM:  w_next = S_MADDR;
                    OP_FMT2: w_next = (IR[24:22] == OP2_BICC) ? S_BR : S_PC_UPD;
                    default: w_next = S_PC_UPD;
                endcase
            end
            S_ALU:     w_next = S_PC_UPD;
            S_MADDR:   w_next = IR[21] ? S_ST_DATA : S_LD_WAIT;
            S_LD_WAIT: begin
                if (MFC)            w_next = S_LD_WB;
                else if (w_expired) w_next = S_TRAP;
            end
            S_LD_WB:   w_next = S_PC_UPD;
            S_ST_DATA: w_next = S_ST_WAIT;
            S_ST_WAIT: begin
                if (MFC)            w_next = S_PC_UPD;
                else if (w_expired) w_next = S_TRAP;
            end
            S_BR:      w_next = w_taken ? S_FETCH1 : S_PC_UPD;
            S_PC_UPD:  w_next = S_FETCH1;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_RST1;
        endcase
    end

    // Output decode from the registered state (plus IR/icc where needed)
    always_comb begin
        le_n    = '1;
        clr_n   = 1'b1;
        MFA     = 1'b0;
        MAR_SEL = 2'd0;
        MDR_SEL = 2'd0;
        nPC_SEL = 2'd0;
        ALU_SEL = 2'd0;
        CIN_SEL = 2'd0;
        RA_SEL  = 1'b0;
        MOP_SEL = 1'b0;
        nPC_ADD = 1'b0;
        alue    = 1'b0;
        trap    = 1'b0;
        case (r_state)
            S_RST1: clr_n = 1'b0;
            S_RST2: begin
                le_n[LE_NPCE] = 1'b0;
                nPC_ADD       = 1'b1;
            end
            S_FETCH1: begin
                MAR_SEL       = MAR_SEL_PC;
                le_n[LE_MARE] = 1'b0;
            end
            S_FETCH2: begin
                MOP_SEL       = MOP_SEL_FETCH;
                MDR_SEL       = MDR_SEL_RAM;
                MFA           = 1'b1;
                le_n[LE_MDRE] = 1'b0;
            end
            S_FETCH3: le_n[LE_IRE] = 1'b0;
            S_ALU: begin
                ALU_SEL       = w_alu_sel;
                RA_SEL        = RA_SEL_RS1;
                CIN_SEL       = CIN_SEL_ALU;
                le_n[LE_RFE]  = 1'b0;
                le_n[LE_PSRE] = 1'b0;
                alue          = 1'b1;
            end
            S_MADDR: begin
                ALU_SEL       = w_alu_sel;
                MAR_SEL       = MAR_SEL_ALU;
                le_n[LE_MARE] = 1'b0;
            end
            S_LD_WAIT: begin
                MOP_SEL       = MOP_SEL_DATA;
                MDR_SEL       = MDR_SEL_RAM;
                MFA           = 1'b1;
                le_n[LE_MDRE] = 1'b0;
            end
            S_LD_WB: begin
                CIN_SEL      = CIN_SEL_MDR;
                le_n[LE_RFE] = 1'b0;
            end
            S_ST_DATA: begin
                RA_SEL        = RA_SEL_RD;
                MDR_SEL       = MDR_SEL_RA;
                le_n[LE_MDRE] = 1'b0;
            end
            S_ST_WAIT: begin
                MOP_SEL = MOP_SEL_DATA;
                MFA     = 1'b1;
            end
            S_BR: begin
                if (w_taken) begin
                    le_n[LE_PCE]  = 1'b0;
                    le_n[LE_NPCE] = 1'b0;
                    nPC_SEL       = nPC_SEL_BR;
                end
            end
            S_PC_UPD: begin
                le_n[LE_PCE]  = 1'b0;
                le_n[LE_NPCE] = 1'b0;
                nPC_SEL       = nPC_SEL_ADD;
                nPC_ADD       = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_sequencer
//  Description : Directed bench for dp_sequencer. The stimulus thread walks
//                instructions cycle by cycle and queues the hand-derived
//                output vector for each cycle; a monitor compares mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_sequencer;
    import dp_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [31:0] IR;
    logic        MFC;
    logic [3:0]  icc;
    logic [6:0]  le_n;
    logic        clr_n, MFA, RA_SEL, MOP_SEL, nPC_ADD, alue, trap;
    logic [1:0]  MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL;
    logic [3:0]  state;

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] le;
        logic       clrn;
        logic       mfa;
        logic [1:0] mar;
        logic [1:0] mdr;
        logic [1:0] npc;
        logic [1:0] alu;
        logic [1:0] cin;
        logic       ra;
        logic       mop;
        logic       nadd;
        logic       alue;
        logic       trap;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    dp_sequencer #(.MFC_TIMEOUT(15)) dut (
        .Clk(Clk), .Clr(Clr), .IR(IR), .MFC(MFC), .icc(icc),
        .le_n(le_n), .clr_n(clr_n), .MFA(MFA),
        .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .nPC_SEL(nPC_SEL),
        .ALU_SEL(ALU_SEL), .CIN_SEL(CIN_SEL), .RA_SEL(RA_SEL),
        .MOP_SEL(MOP_SEL), .nPC_ADD(nPC_ADD), .alue(alue),
        .state(state), .trap(trap)
    );

    always #5 Clk = ~Clk;

    // Hand-written output table per state; alu/tk supplied by the test
    function automatic obs_t mk(input logic [3:0] s, input logic [1:0] alu, input logic tk);
        obs_t e;
        e      = '0;
        e.st   = s;
        e.le   = 7'b1111111;
        e.clrn = 1'b1;
        case (s)
            S_RST1:    e.clrn = 1'b0;
            S_RST2:    begin e.le = 7'b1111011; e.nadd = 1'b1; end
            S_FETCH1:  begin e.le = 7'b1101111; e.mar = 2'd1; end
            S_FETCH2:  begin e.le = 7'b1011111; e.mop = 1'b1; e.mfa = 1'b1; end
            S_FETCH3:  e.le = 7'b0111111;
            S_ALU:     begin e.le = 7'b1111100; e.alu = alu; e.cin = 2'd2; e.alue = 1'b1; end
            S_MADDR:   begin e.le = 7'b1101111; e.alu = alu; end
            S_LD_WAIT: begin e.le = 7'b1011111; e.mfa = 1'b1; end
            S_LD_WB:   begin e.le = 7'b1111101; e.cin = 2'd3; end
            S_ST_DATA: begin e.le = 7'b1011111; e.ra = 1'b1; e.mdr = 2'd1; end
            S_ST_WAIT: e.mfa = 1'b1;
            S_BR:      if (tk) begin e.le = 7'b1110011; e.npc = 2'd2; end
            S_PC_UPD:  begin e.le = 7'b1110011; e.nadd = 1'b1; end
            S_TRAP:    e.trap = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    task automatic push(input logic [3:0] s, input logic [1:0] alu, input logic tk, input string tag);
        exp_q.push_back(mk(s, alu, tk));
        tag_q.push_back(tag);
    endtask

    // One clock: after the edge, drive MFC for this cycle and queue expectation
    task automatic cyc(input logic [3:0] s, input logic mfc, input logic [1:0] alu,
                       input logic tk, input string tag);
        @(posedge Clk);
        #1;
        MFC = mfc;
        push(s, alu, tk, tag);
    endtask

    // Hold RST1 one more cycle, release Clr, expect RST2 next
    task automatic release_reset(input string tag);
        @(posedge Clk);
        #1;
        push(S_RST1, 2'd0, 1'b0, {tag, " rst1"});
        Clr = 1'b1;
        cyc(S_RST2, 1'b0, 2'd0, 1'b0, {tag, " rst2"});
    endtask

    task automatic do_reset(input string tag);
        @(posedge Clk);
        #1;
        Clr = 1'b0;
        MFC = 1'b0;
        push(S_RST1, 2'd0, 1'b0, {tag, " in reset"});
        release_reset(tag);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic [3:0] flags, input int delay,
                         input string tag);
        cyc(S_FETCH1, 1'b0, 2'd0, 1'b0, {tag, " fetch1"});
        IR  = ir;
        icc = flags;
        for (int i = 0; i < delay; i++) cyc(S_FETCH2, 1'b0, 2'd0, 1'b0, {tag, " fetch2 wait"});
        cyc(S_FETCH2, 1'b1, 2'd0, 1'b0, {tag, " fetch2 mfc"});
        cyc(S_FETCH3, 1'b0, 2'd0, 1'b0, {tag, " fetch3"});
        cyc(S_DECODE, 1'b0, 2'd0, 1'b0, {tag, " decode"});
    endtask

    task automatic br(input logic [31:0] ir, input logic [3:0] flags, input logic tk,
                      input string tag);
        fetch(ir, flags, 0, tag);
        cyc(S_BR, 1'b0, 2'd0, tk, {tag, " br"});
        if (!tk) cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, {tag, " pc_upd"});
    endtask

    // Monitor: compare mid-cycle whenever an expectation is pending
    always @(negedge Clk) begin
        obs_t  e, a;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{st: state, le: le_n, clrn: clr_n, mfa: MFA, mar: MAR_SEL, mdr: MDR_SEL,
                  npc: nPC_SEL, alu: ALU_SEL, cin: CIN_SEL, ra: RA_SEL, mop: MOP_SEL,
                  nadd: nPC_ADD, alue: alue, trap: trap};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                         t, a.st, a, e.st, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Clr = 1'b0;
        MFC = 1'b0;
        IR  = 32'h0;
        icc = 4'h0;

        do_reset("por");

        // ALU register form, zero-wait fetch: 6 cycles FETCH1..PC_UPD
        fetch(32'h9C044012, 4'h0, 0, "alu_rs2");
        cyc(S_ALU,    1'b0, 2'd0, 1'b0, "alu_rs2 alu");
        cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, "alu_rs2 pc_upd");

        // ALU immediate form with two fetch wait cycles
        fetch(32'h9C046012, 4'h0, 2, "alu_imm");
        cyc(S_ALU,    1'b0, 2'd1, 1'b0, "alu_imm alu");
        cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, "alu_imm pc_upd");

        // Load, MFC after 3 wait cycles: LD_WAIT for 4 cycles
        fetch(32'hC2006004, 4'h0, 0, "load");
        cyc(S_MADDR, 1'b0, 2'd1, 1'b0, "load maddr");
        for (int i = 0; i < 3; i++) cyc(S_LD_WAIT, 1'b0, 2'd0, 1'b0, "load ld_wait");
        cyc(S_LD_WAIT, 1'b1, 2'd0, 1'b0, "load ld_wait mfc");
        cyc(S_LD_WB,   1'b0, 2'd0, 1'b0, "load ld_wb");
        cyc(S_PC_UPD,  1'b0, 2'd0, 1'b0, "load pc_upd");

        // Store with one wait cycle
        fetch(32'hC2206004, 4'h0, 0, "store");
        cyc(S_MADDR,   1'b0, 2'd1, 1'b0, "store maddr");
        cyc(S_ST_DATA, 1'b0, 2'd0, 1'b0, "store st_data");
        cyc(S_ST_WAIT, 1'b0, 2'd0, 1'b0, "store st_wait");
        cyc(S_ST_WAIT, 1'b1, 2'd0, 1'b0, "store st_wait mfc");
        cyc(S_PC_UPD,  1'b0, 2'd0, 1'b0, "store pc_upd");

        // Branches: icc = {N,Z,V,C}
        br(32'h02800010, 4'b0100, 1'b1, "be z1");
        br(32'h02800010, 4'b1011, 1'b0, "be z0");
        br(32'h12800010, 4'b0000, 1'b1, "bne z0");
        br(32'h12800010, 4'b0100, 1'b0, "bne z1");
        br(32'h10800010, 4'b0000, 1'b1, "ba");
        br(32'h00800010, 4'b0100, 1'b0, "bn");
        br(32'h04800010, 4'b1111, 1'b0, "cond other");

        // Format-00 non-branch and op=01 fall through to PC_UPD
        fetch(32'h01000000, 4'h0, 0, "sethi");
        cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, "sethi pc_upd");
        fetch(32'h40000000, 4'h0, 0, "call");
        cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, "call pc_upd");

        // MFC on the 15th FETCH2 cycle beats the timeout
        fetch(32'h9C044012, 4'h0, 14, "mfc last");
        cyc(S_ALU,    1'b0, 2'd0, 1'b0, "mfc last alu");
        cyc(S_PC_UPD, 1'b0, 2'd0, 1'b0, "mfc last pc_upd");

        // Clr pulsed mid-LD_WAIT: RST1 without a clock edge
        fetch(32'hC2006004, 4'h0, 0, "ld clr");
        cyc(S_MADDR,   1'b0, 2'd1, 1'b0, "ld clr maddr");
        cyc(S_LD_WAIT, 1'b0, 2'd0, 1'b0, "ld clr ld_wait");
        @(posedge Clk);
        #3;
        Clr = 1'b0;
        push(S_RST1, 2'd0, 1'b0, "ld clr async");
        release_reset("ld clr");

        // Fetch timeout: 15 FETCH2 cycles without MFC, then TRAP holds
        cyc(S_FETCH1, 1'b0, 2'd0, 1'b0, "timeout fetch1");
        for (int i = 0; i < 15; i++) cyc(S_FETCH2, 1'b0, 2'd0, 1'b0, "timeout fetch2");
        for (int i = 0; i < 3; i++)  cyc(S_TRAP, 1'b1, 2'd0, 1'b0, "timeout trap");

        // Reset recovers from TRAP
        do_reset("post trap");
        cyc(S_FETCH1, 1'b0, 2'd0, 1'b0, "post trap fetch1");

        @(negedge Clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 SHALL have parameter MFC_TIMEOUT, default 15, giving the maximum cycles spent in any memory wait state before trapping.
REQ-002 SHALL have port Clk  input  1  clock, rising edge.
REQ-003 SHALL have port Clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port IR  input  32  current instruction register contents.
REQ-005 SHALL have port MFC  input  1  memory function complete.
REQ-006 SHALL have port icc  input  4  flags {N,Z,V,C}.
REQ-007 SHALL have port le_n  output  7  active-low load enables {IRE,MDRE,MARE,PCE,nPCE,RFE,PSRE}.
REQ-008 SHALL have port clr_n  output  1  active-low clear to PC, nPC, IR and trap queue.
REQ-009 SHALL have port MFA  output  1  memory function active.
REQ-010 SHALL have ports MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL  output  2 each  datapath mux selects.
REQ-011 SHALL have ports RA_SEL, MOP_SEL, nPC_ADD, alue  output  1 each  RA mux, memory-op mux, nPC increment and ALU-flag enable.
REQ-012 SHALL have ports state  output  4  (debug) and trap  output  1  (MFC timeout).

Function
REQ-013 SHALL be a Moore FSM whose outputs decode only from the registered state and the IR and icc inputs.
REQ-014 SHALL drive these defaults in every state unless overridden: le_n all 1, clr_n=1, MFA=0, all selects 0, nPC_ADD=0, alue=0, trap=0.
REQ-015 SHALL use states RST1=0, RST2=1, FETCH1=2, FETCH2=3, FETCH3=4, DECODE=5, ALU=6, MADDR=7, LD_WAIT=8, LD_WB=9, ST_DATA=10, ST_WAIT=11, BR=12, PC_UPD=13, TRAP=14.
REQ-016 RST1 SHALL set clr_n=0 and then go to RST2.
REQ-017 RST2 SHALL set nPCE=0 and nPC_ADD=1 (nPC becomes 4) and then go to FETCH1.
REQ-018 FETCH1 SHALL set MAR_SEL=1 (PC) and MARE=0, then go to FETCH2.
REQ-019 FETCH2 SHALL set MOP_SEL=1, MDR_SEL=0 (RAM), MFA=1 and MDRE=0; it SHALL stay until MFC=1 is sampled, then go to FETCH3.
REQ-020 FETCH3 SHALL set IRE=0, then go to DECODE.
REQ-021 DECODE SHALL branch on IR[31:30]: 10 goes to ALU; 11 goes to MADDR; 00 with IR[24:22]=010 goes to BR; all other encodings go to PC_UPD.
REQ-022 ALU state outputs:
- ALU_SEL=1 if IR[13]=1, else 0.
- RA_SEL=0, CIN_SEL=2, RFE=0, alue=1, PSRE=0.
- Next state: PC_UPD.
REQ-023 MADDR SHALL set ALU_SEL per IR[13], MAR_SEL=0 (ALU) and MARE=0; next state is ST_DATA if IR[21]=1, else LD_WAIT.
REQ-024 LD_WAIT SHALL set MOP_SEL=0, MDR_SEL=0, MFA=1 and MDRE=0, wait for MFC, then go to LD_WB.
REQ-025 LD_WB SHALL set CIN_SEL=3 (MDR) and RFE=0, then go to PC_UPD.
REQ-026 ST_DATA SHALL set RA_SEL=1, MDR_SEL=1 and MDRE=0, then go to ST_WAIT.
REQ-027 ST_WAIT SHALL set MOP_SEL=0 and MFA=1, wait for MFC, then go to PC_UPD.
REQ-028 BR SHALL evaluate cond=IR[28:25]:
- 1000 taken; 0000 not taken.
- 0001 taken if Z; 1001 taken if !Z.
- Any other cond not taken.
REQ-029 A taken branch in BR SHALL set PCE=0, nPCE=0 and nPC_SEL=2 in the same cycle, then go to FETCH1; a not-taken branch SHALL go to PC_UPD.
REQ-030 PC_UPD SHALL set PCE=0, nPCE=0, nPC_SEL=0 and nPC_ADD=1, then go to FETCH1.
REQ-031 The wait counter SHALL clear on entry to FETCH2, LD_WAIT and ST_WAIT.
REQ-032 If MFC_TIMEOUT cycles elapse without MFC, the FSM SHALL go to TRAP.
REQ-033 MFC=1 sampled on the timeout cycle SHALL take priority over the trap.
REQ-034 TRAP SHALL hold trap=1 and MFA=0 until reset.
REQ-035 Minimum instruction latency SHALL be 6 cycles for ALU and 8 cycles for load (zero-wait MFC).

Reset
REQ-036 Clr=0 SHALL force state to RST1 asynchronously from any state, including wait states.
REQ-037 During reset, MFA=0, clr_n=0 and trap=0 SHALL hold immediately.
REQ-038 The wait counter SHALL reset to 0.
REQ-039 The FSM SHALL leave RST1 on the first rising edge after Clr is deasserted.

Structure
REQ-040 State encodings, mux-select constants (MAR_SEL_ALU=0, MAR_SEL_PC=1, CIN_SEL_ALU=2, CIN_SEL_MDR=3, nPC_SEL_ADD=0, nPC_SEL_BR=2) and IR op/cond constants SHALL reside in shared package dp_ctrl_pkg.
REQ-041 The wait counter and timeout compare SHALL be a sub-module mfc_timer.

Verification
REQ-042 Reset release → RST1, RST2, FETCH1 on successive edges; nPC=4 after RST2; all le_n=1 except as specified.
REQ-043 IR=0x9C044012 (ALU, rs2), MFC on the first FETCH2 cycle → ALU then PC_UPD; RFE=0, CIN_SEL=2 and ALU_SEL=0 in ALU; 6 cycles total.
REQ-044 Load IR=0xC2006004 with MFC delayed 3 cycles → LD_WAIT held 4 cycles, then LD_WB with CIN_SEL=3 and RFE=0.
REQ-045 BE with Z=1 → BR with nPC_SEL=2 and PCE=nPCE=0; with Z=0 → PC_UPD.
REQ-046 MFC held 0 in FETCH2 → TRAP after 15 cycles with trap=1; MFC=1 on cycle 15 → FETCH3 instead.
REQ-047 Clr pulsed low mid-LD_WAIT → MFA=0 and state=RST1 asynchronously.
